// File: rtl/stg_pipe_reg_pkg.sv
// Shared sizes, bubble encoding and entry bundle for the inter-stage pipeline register.
package stg_pipe_reg_pkg;

  localparam int unsigned SIZE_ADDR = 32;
  localparam int unsigned SIZE_DATA = 32;

  // Default bubble instruction (all zeros).
  localparam logic [SIZE_DATA-1:0] NOP_DEFAULT = '0;

  // {pc, instr} pair carried between stages at the default widths.
  typedef struct packed {
    logic [SIZE_ADDR-1:0] pc;
    logic [SIZE_DATA-1:0] instr;
  } ent_t;

  // Number of valid entries held, from the main and skid valid bits.
  function automatic logic [1:0] occ_of(input logic m_v, input logic s_v);
    occ_of = {m_v & s_v, m_v ^ s_v};
  endfunction

endpackage

// File: rtl/stg_pipe_ent.sv
// Single valid+payload register; clear wins over load and restores the bubble payload.
module stg_pipe_ent #(
  parameter int unsigned   W      = 64,
  parameter logic [W-1:0]  BUBBLE = '0
) (
  input  logic         iw_clk,
  input  logic         iw_rst_n,
  input  logic         iw_load,
  input  logic         iw_clr,
  input  logic [W-1:0] iw_d,
  output logic         ow_valid,
  output logic [W-1:0] ow_q
);

  // Entry state: bubble when empty, captured payload when loaded.
  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      ow_valid <= 1'b0;
      ow_q     <= BUBBLE;
    end else if (iw_clr) begin
      ow_valid <= 1'b0;
      ow_q     <= BUBBLE;
    end else if (iw_load) begin
      ow_valid <= 1'b1;
      ow_q     <= iw_d;
    end
  end

endmodule

// File: rtl/stg_pipe_reg.sv
// Inter-stage {pc, instr} pipeline register with handshake, flush, optional skid entry
// and a saturating stall counter.
module stg_pipe_reg
  import stg_pipe_reg_pkg::*;
#(
  parameter int unsigned          ADDR_W      = SIZE_ADDR,
  parameter int unsigned          DATA_W      = SIZE_DATA,
  parameter int unsigned          SKID        = 1,
  parameter logic [DATA_W-1:0]    NOP_INSTR   = '0,
  parameter int unsigned          STALL_CNT_W = 16
) (
  input  logic                   iw_clk,
  input  logic                   iw_rst_n,
  input  logic                   iw_up_valid,
  output logic                   ow_up_ready,
  input  logic [ADDR_W-1:0]      iw_pc,
  input  logic [DATA_W-1:0]      iw_instr,
  output logic                   ow_dn_valid,
  input  logic                   iw_dn_ready,
  output logic [ADDR_W-1:0]      ow_pc,
  output logic [DATA_W-1:0]      ow_instr,
  input  logic                   iw_flush,
  output logic [1:0]             ow_occ,
  output logic [STALL_CNT_W-1:0] ow_stall_cnt
);

  localparam int unsigned ENT_W = ADDR_W + DATA_W;
  localparam logic [ENT_W-1:0] BUBBLE = {{ADDR_W{1'b0}}, NOP_INSTR};

  logic             m_valid, s_valid;
  logic [ENT_W-1:0] m_q, s_q, m_d;
  logic             m_load, m_clr, s_load, s_clr;
  logic             up_fire, dn_fire;

  assign up_fire = iw_up_valid & ow_up_ready;
  assign dn_fire = m_valid & iw_dn_ready;

  // Entry movement: flush first, then drain skid into main, then main/skid capture.
  always_comb begin
    m_load = 1'b0;
    m_clr  = 1'b0;
    s_load = 1'b0;
    s_clr  = 1'b0;
    m_d    = {iw_pc, iw_instr};
    if (iw_flush) begin
      m_clr = 1'b1;
      s_clr = 1'b1;
    end else if (s_valid) begin
      if (dn_fire) begin
        m_load = 1'b1;
        m_d    = s_q;
        s_clr  = 1'b1;
      end
    end else if (!m_valid || dn_fire) begin
      if (up_fire) begin
        m_load = 1'b1;
      end else if (dn_fire) begin
        m_clr = 1'b1;
      end
    end else if (up_fire) begin
      s_load = 1'b1;
    end
  end

  stg_pipe_ent #(
    .W      (ENT_W),
    .BUBBLE (BUBBLE)
  ) u_m (
    .iw_clk   (iw_clk),
    .iw_rst_n (iw_rst_n),
    .iw_load  (m_load),
    .iw_clr   (m_clr),
    .iw_d     (m_d),
    .ow_valid (m_valid),
    .ow_q     (m_q)
  );

  generate
    if (SKID != 0) begin : g_skid
      stg_pipe_ent #(
        .W      (ENT_W),
        .BUBBLE (BUBBLE)
      ) u_s (
        .iw_clk   (iw_clk),
        .iw_rst_n (iw_rst_n),
        .iw_load  (s_load),
        .iw_clr   (s_clr),
        .iw_d     ({iw_pc, iw_instr}),
        .ow_valid (s_valid),
        .ow_q     (s_q)
      );
    end else begin : g_noskid
      logic unused_s;
      assign s_valid  = 1'b0;
      assign s_q      = BUBBLE;
      assign unused_s = s_load ^ s_clr;
    end
  endgenerate

  // Skid mode: ready comes straight from the skid valid flop; otherwise pass-through ready.
  assign ow_up_ready = (SKID != 0) ? !s_valid : (!m_valid || iw_dn_ready);

  assign ow_dn_valid = m_valid;
  assign ow_pc       = m_q[ENT_W-1 -: ADDR_W];
  assign ow_instr    = m_q[DATA_W-1:0];
  assign ow_occ      = occ_of(m_valid, s_valid);

  // Saturating count of cycles where the output entry is held back by downstream.
  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      ow_stall_cnt <= '0;
    end else if (m_valid && !iw_dn_ready && !iw_flush && (ow_stall_cnt != '1)) begin
      ow_stall_cnt <= ow_stall_cnt + STALL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_stg_pipe_reg.sv
// Bench for stg_pipe_reg: skid and non-skid instances against a queue-style reference.
module tb_stg_pipe_reg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        up_v, dn_r, flush;
  logic [31:0] pc, instr;

  logic        a_rdy, a_val, b_rdy, b_val;
  logic [31:0] a_pc, a_in, b_pc, b_in;
  logic [1:0]  a_occ, b_occ;
  logic [3:0]  a_st, b_st;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: per instance, an ordered list of held entries (index 0 is the oldest).
  logic [31:0] m_pc [2][2];
  logic [31:0] m_in [2][2];
  int          m_occ [2];
  int          m_st  [2];

  stg_pipe_reg #(.ADDR_W(32), .DATA_W(32), .SKID(1), .NOP_INSTR(NOP), .STALL_CNT_W(4)) u_a (
    .iw_clk(clk), .iw_rst_n(rst_n), .iw_up_valid(up_v), .ow_up_ready(a_rdy),
    .iw_pc(pc), .iw_instr(instr), .ow_dn_valid(a_val), .iw_dn_ready(dn_r),
    .ow_pc(a_pc), .ow_instr(a_in), .iw_flush(flush), .ow_occ(a_occ), .ow_stall_cnt(a_st));

  stg_pipe_reg #(.ADDR_W(32), .DATA_W(32), .SKID(0), .NOP_INSTR(NOP), .STALL_CNT_W(4)) u_b (
    .iw_clk(clk), .iw_rst_n(rst_n), .iw_up_valid(up_v), .ow_up_ready(b_rdy),
    .iw_pc(pc), .iw_instr(instr), .ow_dn_valid(b_val), .iw_dn_ready(dn_r),
    .ow_pc(b_pc), .ow_instr(b_in), .iw_flush(flush), .ow_occ(b_occ), .ow_stall_cnt(b_st));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit mdl_ready(input int i);
    return (i == 0) ? (m_occ[i] < 2) : (m_occ[i] == 0 || dn_r);
  endfunction

  // Reference update: FIFO of capacity 2 (skid) or 1 (no skid), flush empties it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_occ[i] = 0;
        m_st[i]  = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        bit upf, dnf;
        upf = up_v && mdl_ready(i);
        dnf = (m_occ[i] > 0) && dn_r;
        if (m_occ[i] > 0 && !dn_r && !flush && m_st[i] < 15) m_st[i] = m_st[i] + 1;
        if (flush) begin
          m_occ[i] = 0;
        end else begin
          if (dnf) begin
            m_pc[i][0] = m_pc[i][1];
            m_in[i][0] = m_in[i][1];
            m_occ[i]   = m_occ[i] - 1;
          end
          if (upf) begin
            m_pc[i][m_occ[i]] = pc;
            m_in[i][m_occ[i]] = instr;
            m_occ[i]          = m_occ[i] + 1;
          end
        end
      end
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    chk("a_valid", 32'(a_val), 32'(m_occ[0] > 0));
    chk("a_pc",    a_pc, (m_occ[0] > 0) ? m_pc[0][0] : 32'h0);
    chk("a_instr", a_in, (m_occ[0] > 0) ? m_in[0][0] : NOP);
    chk("a_occ",   32'(a_occ), 32'(m_occ[0]));
    chk("a_ready", 32'(a_rdy), 32'(mdl_ready(0)));
    chk("a_stall", 32'(a_st), 32'(m_st[0]));
    chk("b_valid", 32'(b_val), 32'(m_occ[1] > 0));
    chk("b_pc",    b_pc, (m_occ[1] > 0) ? m_pc[1][0] : 32'h0);
    chk("b_instr", b_in, (m_occ[1] > 0) ? m_in[1][0] : NOP);
    chk("b_occ",   32'(b_occ), 32'(m_occ[1]));
    chk("b_ready", 32'(b_rdy), 32'(mdl_ready(1)));
    chk("b_stall", 32'(b_st), 32'(m_st[1]));
  end

  // Drive one cycle of inputs, return just after the rising edge.
  task automatic cyc(input logic v, input logic [31:0] p, input logic r, input logic f);
    up_v  = v;
    pc    = p;
    instr = 32'h1000_0000 | p;
    dn_r  = r;
    flush = f;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_occ[i] = 0;
      m_st[i]  = 0;
    end
    rst_n = 1'b0;
    up_v = 0; dn_r = 0; flush = 0; pc = 0; instr = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    chk("rst_valid", 32'(a_val), 32'd0);
    chk("rst_instr", a_in, NOP);
    chk("rst_occ",   32'(a_occ), 32'd0);
    chk("rst_ready", 32'(a_rdy), 32'd1);
    chk("rst_stall", 32'(a_st), 32'd0);

    // Streaming with downstream always ready
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 32'h10 + 32'(k), 1'b1, 1'b0);
      chk("stream_pc",    a_pc, 32'h10 + 32'(k));
      chk("stream_valid", 32'(a_val), 32'd1);
      chk("stream_occ",   32'(a_occ), 32'd1);
      chk("stream_b_pc",  b_pc, 32'h10 + 32'(k));
    end
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    chk("drain_valid", 32'(a_val), 32'd0);
    chk("drain_pc",    a_pc, 32'h0);
    chk("stream_stall", 32'(a_st), 32'd0);

    // Skid fill, then release in order
    cyc(1'b1, 32'h20, 1'b0, 1'b0);
    chk("skid_pc0", a_pc, 32'h20);
    cyc(1'b1, 32'h21, 1'b0, 1'b0);
    chk("skid_occ2",  32'(a_occ), 32'd2);
    chk("skid_ready", 32'(a_rdy), 32'd0);
    cyc(1'b1, 32'h22, 1'b0, 1'b0);
    chk("skid_hold_pc", a_pc, 32'h20);
    cyc(1'b1, 32'h22, 1'b1, 1'b0);
    chk("skid_pc1", a_pc, 32'h21);
    cyc(1'b1, 32'h22, 1'b1, 1'b0);
    chk("skid_pc2", a_pc, 32'h22);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    chk("skid_empty", 32'(a_val), 32'd0);
    chk("skid_stall", 32'(a_st), 32'd2);

    // Flush with two held entries, then flush against an accepted entry
    cyc(1'b1, 32'h30, 1'b0, 1'b0);
    cyc(1'b1, 32'h31, 1'b0, 1'b0);
    chk("fl_occ2", 32'(a_occ), 32'd2);
    cyc(1'b1, 32'h32, 1'b0, 1'b1);
    chk("fl_valid", 32'(a_val), 32'd0);
    chk("fl_instr", a_in, NOP);
    chk("fl_occ",   32'(a_occ), 32'd0);
    chk("fl_ready", 32'(a_rdy), 32'd1);
    chk("fl_stall", 32'(a_st), 32'd3);
    cyc(1'b1, 32'h33, 1'b0, 1'b0);
    cyc(1'b1, 32'h34, 1'b0, 1'b1);
    chk("fl2_occ", 32'(a_occ), 32'd0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    chk("fl2_valid", 32'(a_val), 32'd0);
    chk("fl2_stall", 32'(a_st), 32'd3);

    // Stall saturation
    cyc(1'b1, 32'h40, 1'b0, 1'b0);
    repeat (5) cyc(1'b0, 32'h0, 1'b0, 1'b0);
    chk("sat_mid", 32'(a_st), 32'd8);
    repeat (15) cyc(1'b0, 32'h0, 1'b0, 1'b0);
    chk("sat_top", 32'(a_st), 32'd15);
    cyc(1'b0, 32'h0, 1'b0, 1'b0);
    chk("sat_hold", 32'(a_st), 32'd15);
    chk("sat_pc",   a_pc, 32'h40);

    // Asynchronous reset between edges with two entries held
    cyc(1'b1, 32'h50, 1'b0, 1'b0);
    chk("ar_occ2", 32'(a_occ), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(a_val), 32'd0);
    chk("ar_occ",   32'(a_occ), 32'd0);
    chk("ar_pc",    a_pc, 32'h0);
    chk("ar_instr", a_in, NOP);
    chk("ar_ready", 32'(a_rdy), 32'd1);
    chk("ar_stall", 32'(a_st), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Randomized traffic with varying downstream back-pressure
    for (int ph = 0; ph < 10; ph++) begin
      int rdy_pct;
      rdy_pct = (ph % 3 == 0) ? 90 : ((ph % 3 == 1) ? 50 : 15);
      for (int n = 0; n < 200; n++) begin
        cyc($urandom_range(0, 3) != 0, $urandom,
            $urandom_range(0, 99) < rdy_pct, $urandom_range(0, 15) == 0);
      end
    end

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
